// File: rtl/prefix_carry_pipe.sv
// Pipelined Kogge-Stone carry network with a valid/ready stall handshake.
// A register after prefix level k is present when REG_MASK[k] is set.
module prefix_carry_pipe #(
   parameter int                WIDTH    = 8,
   parameter int                LEVELS   = $clog2(WIDTH),
   parameter logic [LEVELS-1:0] REG_MASK = {LEVELS{1'b1}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] g,
   input  logic [WIDTH-1:0] p,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] carry,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             pall
);

   logic             advance;
   logic             acc;
   logic [WIDTH-1:0] g_m;
   logic [WIDTH-1:0] p_m;
   logic [WIDTH-1:0] g_f;
   logic             ci_m;
   logic             out_valid_q;
   logic [WIDTH-1:0] carry_q;
   logic [WIDTH-1:0] sum_q;
   logic             pall_q;
   logic [WIDTH-1:0] carry_d;
   logic [WIDTH-1:0] sum_d;
   logic             pall_d;

   assign advance = !out_valid_q | out_ready;
   assign in_ready = advance;
   assign acc = in_valid & advance;

   // Unaccepted inputs are zeroed so nothing unknown enters a stage.
   assign g_m  = acc ? g : '0;
   assign p_m  = acc ? p : '0;
   assign ci_m = acc & cin;

   always_comb begin
      g_f    = g_m;
      g_f[0] = g_m[0] | (p_m[0] & ci_m);
   end

   for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
      localparam int D = 1 << k;
      logic [WIDTH-1:0] g_in;
      logic [WIDTH-1:0] p_in;
      logic [WIDTH-1:0] op_in;
      logic             ci_in;
      logic             v_in;
      logic [WIDTH-1:0] g_d;
      logic [WIDTH-1:0] p_d;
      logic [WIDTH-1:0] g_q;
      logic [WIDTH-1:0] p_q;
      logic [WIDTH-1:0] op_q;
      logic             ci_q;
      logic             v_q;

      if (k == 0) begin : g_src
         assign g_in  = g_f;
         assign p_in  = p_m;
         assign op_in = p_m;
         assign ci_in = ci_m;
         assign v_in  = acc;
      end else begin : g_src
         assign g_in  = g_lvl[k-1].g_q;
         assign p_in  = g_lvl[k-1].p_q;
         assign op_in = g_lvl[k-1].op_q;
         assign ci_in = g_lvl[k-1].ci_q;
         assign v_in  = g_lvl[k-1].v_q;
      end

      always_comb begin
         g_d = g_in;
         p_d = p_in;
         for (int i = D; i < WIDTH; i++) begin
            g_d[i] = g_in[i] | (p_in[i] & g_in[i-D]);
            p_d[i] = p_in[i] & p_in[i-D];
         end
      end

      if (REG_MASK[k]) begin : g_reg
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               g_q  <= '0;
               p_q  <= '0;
               op_q <= '0;
               ci_q <= 1'b0;
               v_q  <= 1'b0;
            end else if (advance) begin
               g_q  <= g_d;
               p_q  <= p_d;
               op_q <= op_in;
               ci_q <= ci_in;
               v_q  <= v_in;
            end
         end
      end else begin : g_cmb
         assign g_q  = g_d;
         assign p_q  = p_d;
         assign op_q = op_in;
         assign ci_q = ci_in;
         assign v_q  = v_in;
      end
   end

   assign carry_d = g_lvl[LEVELS-1].g_q;
   assign sum_d   = g_lvl[LEVELS-1].op_q
                  ^ {carry_d[WIDTH-2:0], g_lvl[LEVELS-1].ci_q};
   assign pall_d  = g_lvl[LEVELS-1].p_q[WIDTH-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         carry_q     <= '0;
         sum_q       <= '0;
         pall_q      <= 1'b0;
      end else if (advance) begin
         out_valid_q <= g_lvl[LEVELS-1].v_q;
         carry_q     <= carry_d;
         sum_q       <= sum_d;
         pall_q      <= pall_d;
      end
   end

   assign out_valid = out_valid_q;
   assign carry     = carry_q;
   assign sum       = sum_q;
   assign cout      = carry_q[WIDTH-1];
   assign pall      = pall_q;

endmodule

// File: tb/tb_prefix_carry_pipe.sv
// Bench for prefix_carry_pipe: vector table, scoreboard queue and
// hand-written stall, reset and 32-bit partial-mask sequences.
module tb_prefix_carry_pipe;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic       iv, ir, ov, ordy, cin, cout, pall;
   logic [7:0] g, p, carry, sum;

   logic        iv32, ir32, ov32, cin32, cout32, pall32;
   logic [31:0] g32, p32, carry32, sum32;

   prefix_carry_pipe dut8 (
      .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir),
      .g(g), .p(p), .cin(cin), .out_valid(ov), .out_ready(ordy),
      .carry(carry), .sum(sum), .cout(cout), .pall(pall)
   );

   prefix_carry_pipe #(.WIDTH(32), .REG_MASK(5'b00101)) dut32 (
      .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32),
      .g(g32), .p(p32), .cin(cin32), .out_valid(ov32), .out_ready(1'b1),
      .carry(carry32), .sum(sum32), .cout(cout32), .pall(pall32)
   );

   typedef struct {
      logic [7:0] g;
      logic [7:0] p;
      logic       cin;
      logic [7:0] sum;
      logic [7:0] carry;
      logic       cout;
      logic       pall;
   } vec_t;

   vec_t exp_q[$];
   int   iss_q[$];
   vec_t cur;
   vec_t tbl[6];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   bit   chk_lat = 1'b0;
   logic [7:0] hold_s, hold_c;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [7:0] a, input logic [7:0] b,
                               input logic c);
      vec_t v;
      logic cc;
      logic [8:0] s;
      v.g = a & b;
      v.p = a ^ b;
      v.cin = c;
      cc = c;
      for (int i = 0; i < 8; i++) begin
         v.carry[i] = v.g[i] | (v.p[i] & cc);
         cc = v.carry[i];
      end
      s = {1'b0, a} + {1'b0, b} + {8'd0, c};
      v.sum = s[7:0];
      v.cout = s[8];
      v.pall = &v.p;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      cur = v;
      iv = 1'b1;
      g = v.g;
      p = v.p;
      cin = v.cin;
   endtask

   task automatic idle();
      iv = 1'b0;
      g = 8'($urandom);
      p = 8'($urandom);
      cin = 1'($urandom);
   endtask

   task automatic step();
      vec_t e;
      int   t0;
      #1;
      if (ov && ordy) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL stale: unexpected result sum %0h", sum);
         end else begin
            e = exp_q.pop_front();
            t0 = iss_q.pop_front();
            chk("sum", 32'(sum), 32'(e.sum));
            chk("carry", 32'(carry), 32'(e.carry));
            chk("cout", 32'(cout), 32'(e.cout));
            chk("pall", 32'(pall), 32'(e.pall));
            if (chk_lat) chk("latency", 32'(cyc - t0), 32'd4);
         end
      end
      if (iv && ir) begin
         exp_q.push_back(cur);
         iss_q.push_back(cyc);
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic drain(input int lim);
      int n;
      n = 0;
      idle();
      while (exp_q.size() != 0 && n < lim) begin
         step();
         n++;
      end
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: %0d results missing", exp_q.size());
         exp_q.delete();
         iss_q.delete();
      end
   endtask

   task automatic run32(input logic [31:0] gv, input logic [31:0] pv,
                        input logic cv, output int n);
      iv32 = 1'b1;
      g32 = gv;
      p32 = pv;
      cin32 = cv;
      @(posedge clk);
      @(negedge clk);
      iv32 = 1'b0;
      g32 = '0;
      p32 = '0;
      cin32 = 1'b0;
      n = 1;
      while (!ov32 && n < 10) begin
         @(negedge clk);
         n++;
      end
   endtask

   initial begin
      int n;
      logic [31:0] a32, b32;
      logic [32:0] s33;
      iv = 1'b0; ordy = 1'b1; g = '0; p = '0; cin = 1'b0;
      iv32 = 1'b0; g32 = '0; p32 = '0; cin32 = 1'b0;
      tbl[0] = '{8'h01, 8'hFE, 1'b0, 8'h00, 8'hFF, 1'b1, 1'b0};
      tbl[1] = '{8'h12, 8'h69, 1'b0, 8'h8D, 8'h72, 1'b0, 1'b0};
      tbl[2] = '{8'h12, 8'h69, 1'b1, 8'h8E, 8'h73, 1'b0, 1'b0};
      tbl[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 8'h00, 1'b0, 1'b0};
      tbl[4] = '{8'h00, 8'hFF, 1'b1, 8'h00, 8'hFF, 1'b1, 1'b1};
      tbl[5] = '{8'h00, 8'hFF, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b1};

      @(negedge clk);
      #1;
      chk("rst_ov", 32'(ov), 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_carry", 32'(carry), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      chk("rst_pall", 32'(pall), 32'd0);
      chk("rst_ov32", 32'(ov32), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_ready", 32'(ir), 32'd1);

      chk_lat = 1'b1;
      for (int i = 0; i < 6; i++) begin
         drive(tbl[i]);
         step();
         drain(10);
      end

      for (int i = 0; i < 16; i++) begin
         drive(mk(8'($urandom), 8'($urandom), 1'($urandom)));
         step();
      end
      drain(10);

      chk_lat = 1'b0;
      ordy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(mk(8'($urandom), 8'($urandom), 1'($urandom)));
         step();
      end
      drive(mk(8'($urandom), 8'($urandom), 1'($urandom)));
      #1;
      chk("stall_ov", 32'(ov), 32'd1);
      hold_s = sum;
      hold_c = carry;
      for (int j = 0; j < 5; j++) begin
         drive(mk(8'($urandom), 8'($urandom), 1'($urandom)));
         #1;
         chk("stall_ready", 32'(ir), 32'd0);
         chk("stall_ov_hold", 32'(ov), 32'd1);
         chk("stall_sum", 32'(sum), 32'(hold_s));
         chk("stall_carry", 32'(carry), 32'(hold_c));
         step();
      end
      ordy = 1'b1;
      drain(10);
      for (int j = 0; j < 3; j++) step();

      ordy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(mk(8'($urandom), 8'($urandom), 1'($urandom)));
         step();
      end
      drive(mk(8'($urandom), 8'($urandom), 1'($urandom)));
      #1;
      chk("pre_rst_ov", 32'(ov), 32'd1);
      #1;
      rst = 1'b1;
      #1;
      chk("mid_rst_ov", 32'(ov), 32'd0);
      chk("mid_rst_sum", 32'(sum), 32'd0);
      chk("mid_rst_carry", 32'(carry), 32'd0);
      chk("mid_rst_cout", 32'(cout), 32'd0);
      chk("mid_rst_pall", 32'(pall), 32'd0);
      exp_q.delete();
      iss_q.delete();
      @(negedge clk);
      rst = 1'b0;
      ordy = 1'b1;
      chk_lat = 1'b1;
      drive(tbl[1]);
      step();
      drain(10);
      for (int j = 0; j < 4; j++) step();

      #1;
      chk("w32_ready", 32'(ir32), 32'd1);
      run32(32'h0, 32'hFFFF_FFFF, 1'b1, n);
      chk("w32_latency", 32'(n), 32'd3);
      chk("w32_carry", carry32, 32'hFFFF_FFFF);
      chk("w32_sum", sum32, 32'h0);
      chk("w32_cout", 32'(cout32), 32'd1);
      chk("w32_pall", 32'(pall32), 32'd1);
      a32 = 32'h9ABC_DEF0;
      b32 = 32'h8765_4321;
      s33 = {1'b0, a32} + {1'b0, b32};
      run32(a32 & b32, a32 ^ b32, 1'b0, n);
      chk("w32b_latency", 32'(n), 32'd3);
      chk("w32b_sum", sum32, s33[31:0]);
      chk("w32b_cout", 32'(cout32), 32'(s33[32]));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run did not complete");
      $fatal(1, "timeout");
   end

endmodule
